g_nnor_filt: RTL

Parametrised successor to the fixed 4-input active-low NOR gate macro: a WIDTH-input NOR of active-low inputs with optional synchronisation, per-input glitch filtering, per-input masking, minimum-assert stretching, an event pulse and sticky source flags. It sits between asynchronous active-low fault/request lines and synchronous control logic. Its output YN follows the gate's logic: YN high when every unmasked input is high (inactive), low when any unmasked input is low (asserted).

---
 rtl/g_nnor_filt.sv | 102 ++++++++++
 1 files changed

// File: rtl/g_nnor_filt.sv
// Purpose: WIDTH-input NOR of filtered, maskable active-low lines with minimum-low stretch, event pulse and sticky flags.
// Latency: an input change reaches YN 2*SYNC+FILT edges after it is first sampled; STS sets on the edge YN falls.
// Backpressure: none; a free-running sampler that evaluates its inputs on every clock.
module g_nnor_filt #(
  parameter int WIDTH   = 4,
  parameter int SYNC    = 1,
  parameter int FILT    = 2,
  parameter int STRETCH = 3
) (
  input  logic             CK,
  input  logic             CD,
  input  logic [WIDTH-1:0] AN,
  input  logic [WIDTH-1:0] MSK,
  input  logic             CLR,
  output logic             YN,
  output logic             EVT,
  output logic [WIDTH-1:0] STS
);

  // Counter compares are done at 8 bits; FILT and STRETCH are limited to 255.
  localparam logic [7:0] FILT_LAST = 8'(FILT - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(STRETCH);

  logic [WIDTH-1:0] s_dat;    // synchronised inputs
  logic [WIDTH-1:0] f_dat;    // filtered inputs, idle high
  logic [WIDTH-1:0] act;      // asserted and unmasked
  logic             any_act;
  logic [7:0]       cnt [WIDTH];
  logic [7:0]       hold;

  generate
    if (SYNC != 0) begin : g_sync
      logic [WIDTH-1:0] meta;
      logic [WIDTH-1:0] sync;
      // two-flop synchroniser, parked at the inactive (high) level while cleared
      always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
          meta <= '1;
          sync <= '1;
        end else begin
          meta <= AN;
          sync <= meta;
        end
      end
      assign s_dat = sync;
    end else begin : g_nosync
      assign s_dat = AN;
    end
  endgenerate

  // per-bit glitch filter: F follows S only after FILT consecutive differing samples
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      f_dat <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s_dat[i] == f_dat[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FILT_LAST) begin
          f_dat[i] <= s_dat[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Masking is applied after the filter so MSK takes effect immediately.
  assign act     = ~f_dat & ~MSK;
  assign any_act = |act;

  // output register with minimum-low stretch and first-low-cycle event
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      YN   <= 1'b1;
      EVT  <= 1'b0;
      hold <= '0;
    end else begin
      EVT <= YN & any_act;
      if (any_act)
        YN <= 1'b0;
      else if (hold == 8'd0)
        YN <= 1'b1;
      // hold loads only on the falling edge; re-assertion while low does not extend it
      if (YN && any_act)
        hold <= HOLD_LOAD;
      else if (hold != 8'd0)
        hold <= hold - 8'd1;
    end
  end

  // sticky source flags; a new assertion wins over a simultaneous clear
  always_ff @(posedge CK or posedge CD) begin
    if (CD)
      STS <= '0;
    else
      STS <= (STS & ~{WIDTH{CLR}}) | act;
  end

endmodule
